// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - N-way round-robin valid/ready mux with registered output
// Optional packet locking (in_last/out_last) enabled by defining RR_MUX_PKT_LOCK_EN.
module rr_mux_arb #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
`ifdef RR_MUX_PKT_LOCK_EN
    input  logic [N-1:0]       in_last,
    output logic               out_last,
`endif
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] gnt;
    logic [SEL_W-1:0] nxt_ptr;
    logic             found;
    logic             load;
    logic             xfer;

`ifdef RR_MUX_PKT_LOCK_EN
    logic             locked;
`endif

    always_comb begin : p_grant
        int idx;
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                gnt   = SEL_W'(idx);
            end
        end
`ifdef RR_MUX_PKT_LOCK_EN
        // While locked, out_sel still names the channel that opened the packet.
        if (locked) begin
            gnt   = out_sel;
            found = in_valid[out_sel];
        end
`endif
    end

    assign load     = !out_valid || out_ready;
    assign xfer     = !rst && load && found;
    assign in_ready = xfer ? ({{(N-1){1'b0}}, 1'b1} << gnt) : '0;
    assign nxt_ptr  = (gnt == SEL_W'(N - 1)) ? '0 : gnt + SEL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
`ifdef RR_MUX_PKT_LOCK_EN
            out_last  <= 1'b0;
            locked    <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt)*WIDTH +: WIDTH];
            out_sel   <= gnt;
`ifdef RR_MUX_PKT_LOCK_EN
            out_last  <= in_last[gnt];
            locked    <= !in_last[gnt];
            if (in_last[gnt]) begin
                rr_ptr <= nxt_ptr;
            end
`else
            rr_ptr    <= nxt_ptr;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb/tb_rr_mux_arb.sv - scoreboard bench for rr_mux_arb (N=4, WIDTH=8)
module tb_rr_mux_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;
`ifdef RR_MUX_PKT_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
`endif

    rr_mux_arb #(.WIDTH(8), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         m_ptr;
    bit         m_valid;
    bit         m_lock;
    int         m_lsel;
    logic [7:0] m_data;
    logic [7:0] dat [4];
    logic [3:0] lastv;
    int         q [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_lock  = 1'b0;
        m_lsel  = 0;
        q.delete();
    endtask

    // Drive one cycle of stimulus, predict the grant, then check the registered result.
    task automatic cycle(input logic [3:0] v, input logic r);
        int         g;
        int         e;
        int         idx;
        bit         found;
        bit         load;
        bit         xfer;
        logic [3:0] er;
        in_valid  = v;
        out_ready = r;
        for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = dat[i];
`ifdef RR_MUX_PKT_LOCK_EN
        in_last = lastv;
`endif
        load  = !m_valid || r;
        found = 1'b0;
        g     = 0;
        if (m_lock) begin
            g     = m_lsel;
            found = v[g];
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (!found && v[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
        xfer = load && found;
        er   = xfer ? 4'(1 << g) : 4'b0000;
        #1;
        check("in_ready", 32'(in_ready), 32'(er));
        if (xfer) begin
            q.push_back((int'(lastv[g]) << 16) | (g << 8) | int'(dat[g]));
            m_lock = !lastv[g];
            m_lsel = g;
            if (lastv[g]) m_ptr = (g + 1) % 4;
        end
        @(posedge clk);
        #1;
        if (xfer) m_valid = 1'b1;
        else if (r) m_valid = 1'b0;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("rr_ptr", 32'(dut.rr_ptr), 32'(m_ptr));
        if (xfer) begin
            e      = q.pop_front();
            m_data = 8'(e);
            check("out_sel", 32'(out_sel), 32'((e >> 8) & 3));
            check("out_data", 32'(out_data), 32'(e & 255));
`ifdef RR_MUX_PKT_LOCK_EN
            check("out_last", 32'(out_last), 32'((e >> 16) & 1));
`endif
        end else if (m_valid) begin
            check("out_hold", 32'(out_data), 32'(m_data));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = '0;
        out_ready = 1'b1;
        lastv     = 4'hF;
`ifdef RR_MUX_PKT_LOCK_EN
        in_last   = 4'hF;
`endif
        dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'h32; dat[3] = 8'h43;
        model_reset();
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;

        // All channels valid: 0,1,2,3,0,1 at full rate.
        for (int i = 0; i < 6; i++) cycle(4'hF, 1'b1);

        // Single channel, then wrap-around to ch1 from rr_ptr=3.
        dat[2] = 8'hA5;
        cycle(4'b0100, 1'b1);
        cycle(4'b0010, 1'b1);

        // Backpressure for three cycles, then drain+load in the same cycle.
        for (int i = 0; i < 3; i++) cycle(4'hF, 1'b0);
        cycle(4'b1000, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Asynchronous reset between clock edges.
        cycle(4'hF, 1'b1);
        cycle(4'hF, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(4'hF, 1'b1);

`ifdef RR_MUX_PKT_LOCK_EN
        // ch1 sends a 3-beat packet while ch0 and ch2 compete.
        lastv = 4'b1101;
        cycle(4'b0111, 1'b1);
        cycle(4'b0111, 1'b1);
        lastv = 4'hF;
        cycle(4'b0111, 1'b1);
        cycle(4'b0111, 1'b1);
`endif
        cycle(4'b0000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N-way channel multiplexer with valid/ready handshakes on every input and on the output.
- Round-robin arbitration picks the input channel.
- The output is registered, giving one cycle of latency.
- Successor to the fixed combinational 4:1 select: the selector is now generated internally by a fair arbiter, not driven from outside.
- Sits between multiple producers (e.g. per-head result streams) and a single shared consumer datapath.

Parameters:
- WIDTH, 8: data width per channel, in bits (>=1).
- N, 4: number of input channels (>=2).
- SEL_W, $clog2(N): localparam; width of the channel index.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-channel data valid.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds valid data.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset is asynchronous: the clock and reset are as stated above, and reset acts immediately, with no clock edge needed. While rst is high:
  - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
  - in_ready=0.
- load = !out_valid || out_ready. The output slot is free, or is being drained this cycle.
- Grant: the first channel g with in_valid[g]=1, searching from rr_ptr upward modulo N. Grant is combinational from in_valid and rr_ptr.
- in_ready[g] = load && in_valid[g] for the granted g only; all other in_ready bits are 0. in_ready is 0 whenever no channel is valid.
- Transfer on a channel happens when in_valid[i] && in_ready[i] at the clock edge. On transfer:
  - out_data <= channel g data.
  - out_sel <= g.
  - out_valid <= 1.
  - rr_ptr <= (g+1) mod N. Wrap-around: g=N-1 gives rr_ptr=0.
- Drain with no transfer: if out_valid && out_ready and no channel is valid, out_valid <= 0. out_data and out_sel hold their last value.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one. out_valid stays 1, giving full throughput of one beat per cycle.
- Stall (out_valid && !out_ready):
  - All in_ready=0.
  - out_data, out_sel and rr_ptr hold.
  - Producers must hold in_valid/in_data stable; this is a producer obligation and is not checked.
- Latency: a beat accepted at edge k appears on out_* after edge k.
- Fairness: a continuously valid channel waits at most N-1 grants.
- rr_ptr is unchanged when there is no transfer.
- Reset mid-transfer: the beat held in the output register is discarded; nothing is replayed.
- No combinational path from out_ready to out_data. There is a combinational path from out_ready to in_ready (by design).

Optional Feature:
- Macro: RR_MUX_PKT_LOCK_EN.
- With the macro defined:
  - Adds ports in_last (input, N) and out_last (output, 1). out_last resets to 0 and is registered alongside out_data.
  - A lock flag (reset 0) is set on transfer of a beat with in_last=0.
  - While locked, grant is forced to the locked channel; other channels get in_ready=0 even if valid.
  - The lock clears on transfer of a beat with in_last=1.
  - rr_ptr advances only on the last beat.
  - A single-beat packet (last=1) behaves exactly like the default mode.
- Without the macro:
  - No in_last/out_last ports and no lock flag.
  - Every beat is arbitrated independently.

Test Plan:
- Reset, N=4, WIDTH=8: rst high with all in_valid=4'hF -> out_valid=0, in_ready=0, out_sel=0. Release reset -> the first grant is channel 0.
- in_valid=4'hF held, out_ready=1, data ch0..3 = 8'h10, 8'h21, 8'h32, 8'h43 -> out_sel sequence 0,1,2,3,0,1, one beat per cycle, out_data matching the channel.
- Only ch2 valid (data 8'hA5), out_ready=1 -> in_ready=4'b0100, out_data=8'hA5, out_sel=2 one cycle later, rr_ptr=3. Then only ch1 valid -> grant wraps to ch1.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles -> in_ready=0 and out_data stable. Raise out_ready with ch3 valid -> same-cycle drain+load, out_valid never drops.
- Async reset asserted mid-stream between clock edges -> out_valid falls immediately. After release, the grant restarts from ch0.
- RR_MUX_PKT_LOCK_EN defined: ch1 sends 3 beats (last on the 3rd) while ch0 and ch2 are also valid -> out_sel=1,1,1 then 2; out_last=1 only on the 3rd beat.
